logged_evt_rx: RTL and testbench
================================

// Module: logged_evt_rx
// PURPOSE
//  Y_CLK-domain consumer of the logged_sync level handshake. Converts each logged high episode on
//  the synchronized Y level into one queued event with a valid/ready interface to downstream logic.
//  Drives clr_Y back to the sync cell on acceptance.
//  Flags overflow and a stuck-high Y (source never released).
// PARAMETERS
//  CNT_W      4   width of pending-event counter; saturates at 2**CNT_W-1
//  STUCK_CYC  64  Y high longer than this many Y_CLK cycles => stuck error (>=2)
//  STUCK_W    7   width of high-time counter; must hold STUCK_CYC
// PORTS
//  Y_CLK      in   1      receive-domain clock
//  Y_RST      in   1      asynchronous, active-high reset
//  ENABLE     in   1      0: rising edges of Y_LOG ignored (edge detector still tracks)
//  Y_LOG      in   1      synchronized level from logged_sync Y; already 2-flop synced, no resync here
//  EVT_READY  in   1      downstream accepts one event when EVT_VALID & EVT_READY
//  FLAG_CLR   in   1      clears OVF and STUCK (1-cycle pulse)
//  EVT_VALID  out  1      pending count nonzero
//  EVT_CNT    out  CNT_W  current pending-event count
//  CLR_Y      out  1      1-cycle pulse on each accepted event; wires to logged_sync clr_Y
//  OVF        out  1      sticky: event arrived while count saturated
//  STUCK      out  1      sticky: Y_LOG high > STUCK_CYC cycles
// BEHAVIOUR
//  Reset
//  - All outputs 0.
//  - y_q = 0, count = 0, high counter = 0, FSM = IDLE.
//  - Y_LOG already high at reset release is not an event (y_q must first see 0).
//  Edge detect
//  - rise = Y_LOG & ~y_q & ENABLE; y_q <= Y_LOG every cycle.
//  - Y_LOG rises in cycle t => EVT_VALID high from t+1 (latency 1).
//  Handshake
//  - acc = EVT_VALID & EVT_READY.
//  - count' = count + rise - acc; 4-way case, no wrap ever.
//  - rise & acc same cycle: count unchanged, EVT_VALID stays high.
//  - CLR_Y is registered: it pulses the cycle after acc, exactly 1 cycle per accepted event.
//  - EVT_VALID may drop only after an acceptance that leaves count = 0.
//    EVT_READY has no effect when EVT_VALID = 0.
//  Saturation
//  - rise & ~acc & count == max: count holds at max, OVF <= 1.
//  - The event is lost; OVF stays set until FLAG_CLR.
//  FSM on Y_LOG (3 states)
//  - IDLE: Y_LOG = 0, high counter = 0. Y_LOG = 1 -> HIGH.
//  - HIGH: high counter increments, saturating at STUCK_CYC.
//    Y_LOG = 0 -> IDLE. counter reaches STUCK_CYC with Y_LOG = 1 -> STUCKED and STUCK <= 1.
//  - STUCKED: no further events counted, even if ENABLE toggles.
//    Y_LOG = 0 -> IDLE. STUCK remains set until FLAG_CLR.
//  Flag clear
//  - FLAG_CLR has priority over a same-cycle set: flags read 0 next cycle.
//  - Exception: a new set condition in the following cycle sets the flag again.
//  Glitch rule
//  - A 1-cycle low on Y_LOG between highs counts as two events; the source protocol guarantees
//    episodes are separated.
//  Reset mid-operation
//  - Y_RST asserts asynchronously and discards pending events.
//  - No CLR_Y is issued for discarded events.
// STRUCTURE
//  - Shared include cdc_lib_defs.vh: FSM state localparams (IDLE = 2'd0, HIGH = 2'd1, STUCKED = 2'd2).
//  - Sub-module sat_updn_cnt #(W): saturating up/down counter with inc, dec, sat flag outputs.
//    Reusable for the A-side event log.
//  - Top: edge detect, FSM + high counter, CLR_Y/flag registers.
// TESTING
//  1. Reset, Y_LOG 0->1 held 5 cycles, EVT_READY = 0 -> EVT_VALID = 1 at t+1, EVT_CNT = 1, CLR_Y = 0.
//  2. Then EVT_READY = 1 one cycle -> EVT_CNT = 0, EVT_VALID = 0 next cycle,
//     CLR_Y pulses exactly 1 cycle.
//  3. CNT_W = 2, 4 episodes with EVT_READY = 0 -> EVT_CNT = 3, OVF = 1.
//     FLAG_CLR -> OVF = 0, count stays 3.
//  4. count = 1, Y_LOG rise in the same cycle as acceptance -> EVT_CNT stays 1, CLR_Y pulses once.
//  5. STUCK_CYC = 8, Y_LOG held high 20 cycles -> STUCK = 1 after cycle 9, exactly one event counted.
//     Y_LOG low then high -> new event counted.
//  6. Y_LOG high at reset release, or ENABLE = 0 during a rise -> no event.
//     Y_RST mid-run with count = 2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/logged_evt_rx_pkg.sv
// Shared types for the Y-domain logged-event receiver.
// Holds the high-level FSM state encoding used by the top.
package logged_evt_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HIGH    = 2'd1,
        ST_STUCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/logged_evt_rx_sat_updn_cnt.sv
// Saturating up/down counter: inc and dec together hold, never wraps in either direction.
// Intended to be reused for the A-side event log as well.
module logged_evt_rx_sat_updn_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_d, cnt_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        case ({inc_i, dec_i})
            2'b10:   if (!sat_o)         cnt_d = cnt_q + 1'b1;
            2'b01:   if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == '1);

endmodule

// File: rtl/logged_evt_rx.sv
// Y_CLK-domain consumer of the logged_sync level handshake: queues one event per Y high episode,
// returns CLR_Y per accepted event, and flags overflow and a stuck-high Y.
module logged_evt_rx
    import logged_evt_rx_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int STUCK_CYC = 64,
    parameter int STUCK_W   = 7
) (
    input  logic             Y_CLK,
    input  logic             Y_RST,
    input  logic             ENABLE,
    input  logic             Y_LOG,
    input  logic             EVT_READY,
    input  logic             FLAG_CLR,
    output logic             EVT_VALID,
    output logic [CNT_W-1:0] EVT_CNT,
    output logic             CLR_Y,
    output logic             OVF,
    output logic             STUCK
);

    localparam logic [STUCK_W-1:0] STUCK_LIM = STUCK_W'(STUCK_CYC);

    logic               y_q, arm_q, clr_q, ovf_q, stuck_q;
    logic [STUCK_W-1:0] hcnt_q;
    rx_state_e          state_q;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_sat, rise, acc, ovf_set, stuck_set;

    // arm_q keeps a level already high at reset release from being taken as an event.
    assign rise      = Y_LOG & ~y_q & arm_q & ENABLE & (state_q != ST_STUCKED);
    assign EVT_VALID = (cnt != '0);
    assign acc       = EVT_VALID & EVT_READY;
    assign ovf_set   = rise & ~acc & cnt_sat;
    assign stuck_set = (state_q == ST_HIGH) & Y_LOG & (hcnt_q == STUCK_LIM);

    logged_evt_rx_sat_updn_cnt #(.W(CNT_W)) u_cnt (
        .clk_i (Y_CLK),
        .rst_i (Y_RST),
        .inc_i (rise),
        .dec_i (acc),
        .cnt_o (cnt),
        .sat_o (cnt_sat)
    );

    always_ff @(posedge Y_CLK or posedge Y_RST) begin
        if (Y_RST) begin
            y_q   <= 1'b0;
            arm_q <= 1'b0;
            clr_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            y_q   <= Y_LOG;
            clr_q <= acc;
            if (!Y_LOG)        arm_q <= 1'b1;
            if (FLAG_CLR)      ovf_q <= 1'b0;
            else if (ovf_set)  ovf_q <= 1'b1;
        end
    end

    // High-time FSM: hcnt_q counts sampled high cycles of the current episode.
    always_ff @(posedge Y_CLK or posedge Y_RST) begin
        if (Y_RST) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hcnt_q <= '0;
                    if (Y_LOG) begin
                        state_q <= ST_HIGH;
                        hcnt_q  <= STUCK_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!Y_LOG) begin
                        state_q <= ST_IDLE;
                        hcnt_q  <= '0;
                    end else if (hcnt_q == STUCK_LIM) begin
                        state_q <= ST_STUCKED;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                ST_STUCKED: begin
                    if (!Y_LOG) begin
                        state_q <= ST_IDLE;
                        hcnt_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hcnt_q  <= '0;
                end
            endcase
            if (FLAG_CLR)       stuck_q <= 1'b0;
            else if (stuck_set) stuck_q <= 1'b1;
        end
    end

    assign EVT_CNT = cnt;
    assign CLR_Y   = clr_q;
    assign OVF     = ovf_q;
    assign STUCK   = stuck_q;

endmodule

// File: tb/tb_logged_evt_rx.sv
// Scoreboarded bench for logged_evt_rx: a behavioural model predicts every cycle's outputs,
// a monitor compares them; directed scenarios are followed by randomized episodes.
module tb_logged_evt_rx;

    localparam int CNT_W     = 2;
    localparam int STUCK_CYC = 8;
    localparam int STUCK_W   = 4;
    localparam int MAX_CNT   = (1 << CNT_W) - 1;

    logic             Y_CLK = 1'b0;
    logic             Y_RST, ENABLE, Y_LOG, EVT_READY, FLAG_CLR;
    logic             EVT_VALID, CLR_Y, OVF, STUCK;
    logic [CNT_W-1:0] EVT_CNT;

    logged_evt_rx #(.CNT_W(CNT_W), .STUCK_CYC(STUCK_CYC), .STUCK_W(STUCK_W)) dut (
        .Y_CLK     (Y_CLK),
        .Y_RST     (Y_RST),
        .ENABLE    (ENABLE),
        .Y_LOG     (Y_LOG),
        .EVT_READY (EVT_READY),
        .FLAG_CLR  (FLAG_CLR),
        .EVT_VALID (EVT_VALID),
        .EVT_CNT   (EVT_CNT),
        .CLR_Y     (CLR_Y),
        .OVF       (OVF),
        .STUCK     (STUCK)
    );

    always #5 Y_CLK = ~Y_CLK;

    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] cnt;
        logic             clr;
        logic             ovf;
        logic             stuck;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: pending events as an integer, run length of the current high level.
    int m_pend, m_run;
    bit m_prev, m_seen_low, m_clr, m_ovf, m_stuck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.valid = EVT_VALID;
        o.cnt   = EVT_CNT;
        o.clr   = CLR_Y;
        o.ovf   = OVF;
        o.stuck = STUCK;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.valid = (m_pend > 0);
        o.cnt   = CNT_W'(m_pend);
        o.clr   = m_clr;
        o.ovf   = m_ovf;
        o.stuck = m_stuck;
        return o;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_run = 0; m_prev = 0; m_seen_low = 0;
        m_clr = 0; m_ovf = 0; m_stuck = 0;
    endtask

    task automatic model_step(input bit en, input bit y, input bit rdy, input bit fclr);
        bit acc, new_episode, ovf_hit, stuck_hit;
        int next;
        acc         = (m_pend > 0) && rdy;
        new_episode = y && !m_prev && m_seen_low && en;
        next        = m_pend + (new_episode ? 1 : 0) - (acc ? 1 : 0);
        ovf_hit     = 0;
        if (next > MAX_CNT) begin
            next    = MAX_CNT;
            ovf_hit = 1;
        end
        m_run     = y ? m_run + 1 : 0;
        stuck_hit = (m_run == STUCK_CYC + 1);
        m_ovf     = fclr ? 1'b0 : (m_ovf | ovf_hit);
        m_stuck   = fclr ? 1'b0 : (m_stuck | stuck_hit);
        m_clr     = acc;
        m_pend    = next;
        m_prev    = y;
        if (!y) m_seen_low = 1;
    endtask

    task automatic step(input bit en, input bit y, input bit rdy, input bit fclr);
        @(negedge Y_CLK);
        ENABLE    = en;
        Y_LOG     = y;
        EVT_READY = rdy;
        FLAG_CLR  = fclr;
        model_step(en, y, rdy, fclr);
        exp_q.push_back(model_obs());
    endtask

    task automatic apply_reset(input bit y_level);
        @(negedge Y_CLK);
        Y_LOG = y_level;
        #2 Y_RST = 1'b1;
        #1 check("async reset clears outputs", 32'(dut_obs()), 32'd0);
        exp_q.delete();
        model_reset();
        @(negedge Y_CLK);
        Y_RST = 1'b0;
    endtask

    // Monitor: every post-edge sample is compared against the oldest prediction.
    initial begin
        forever begin
            @(posedge Y_CLK);
            #1;
            cyc++;
            if (!Y_RST && exp_q.size() > 0) begin
                obs_t e;
                e = exp_q.pop_front();
                check($sformatf("cycle %0d {valid,cnt,clr,ovf,stuck}", cyc), 32'(dut_obs()), 32'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ry, ren, rrdy, rfclr;
        int remain;

        Y_RST = 1'b1; ENABLE = 1'b1; Y_LOG = 1'b0; EVT_READY = 1'b0; FLAG_CLR = 1'b0;
        model_reset();
        repeat (2) @(negedge Y_CLK);
        Y_RST = 1'b0;
        #1 check("reset state", 32'(dut_obs()), 32'd0);

        // One episode held 5 cycles, then a single acceptance.
        step(1, 0, 0, 0);
        repeat (5) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0);

        // Four episodes against a 3-deep counter, then flag clear.
        repeat (4) begin
            step(1, 1, 0, 0);
            step(1, 0, 0, 0);
        end
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);

        // Drain to one, then rise coinciding with acceptance.
        repeat (2) step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        repeat (2) step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);

        // Stuck-high: 20 cycles high, then a fresh episode; exact-limit episode does not flag.
        repeat (20) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 1, 1);
        repeat (3) step(1, 0, 1, 0);
        repeat (STUCK_CYC) step(1, 1, 1, 0);
        step(1, 0, 1, 0);

        // Flag clear coinciding with the stuck set condition wins.
        repeat (STUCK_CYC) step(1, 1, 1, 0);
        step(1, 1, 1, 1);
        repeat (4) step(1, 1, 1, 0);
        step(1, 0, 1, 0);

        // Level high across reset release, and a rise while disabled, are not events.
        apply_reset(1'b1);
        repeat (3) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        apply_reset(1'b0);
        step(1, 0, 0, 0);

        // Randomized episodes with occasional long highs, glitches, clears and resets.
        ry = 0; remain = 2;
        for (int i = 0; i < 1500; i++) begin
            if (remain == 0) begin
                ry = ~ry;
                if (ry) remain = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 14) : $urandom_range(1, 6);
                else    remain = $urandom_range(1, 5);
            end
            remain--;
            ren   = ($urandom_range(0, 7) != 0);
            rrdy  = ($urandom_range(0, 2) == 0);
            rfclr = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 399) == 0) apply_reset(ry);
            step(ren, ry, rrdy, rfclr);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge Y_CLK);
        #2 check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
